// File: rtl/pcie_ats_csr.sv
// pcie_ats_csr
// Memory-mapped control/status block for a PCIe feature region on an
// AXI4-Lite style slave port. The port is 64 bits wide.
//
// Register map, as byte offsets from BASE_ADDR:
//   0x00  DFH         read-only, returns DFH_VALUE
//   0x08  SCRATCHPAD  read/write, 64 bits
//   0x28  TESTPAD     read/write, 64 bits
//
// Any address outside the 4 KB window answers DECERR. Write data is discarded.
// The write channel and the read channel each have their own small FSM.
// They run independently of each other.
// Every handshake and response output comes straight from a flop.

module pcie_ats_csr #(
    parameter logic [19:0] BASE_ADDR = 20'h10000,
    parameter logic [63:0] DFH_VALUE = 64'h3000_0000_1000_0010
) (
    input  logic        clk,
    input  logic        rst,
    // write address channel
    input  logic        awvalid,
    output logic        awready,
    input  logic [19:0] awaddr,
    // write data channel
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    // write response channel
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    // read address channel
    input  logic        arvalid,
    output logic        arready,
    input  logic [19:0] araddr,
    // read data channel
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word index inside the window, taken from addr[11:3]
    localparam logic [8:0] OFS_DFH     = 9'd0;
    localparam logic [8:0] OFS_SCRATCH = 9'd1;
    localparam logic [8:0] OFS_TESTPAD = 9'd5;

    // Returns 1 when the address falls inside the 4 KB feature window
    function automatic logic addr_hit(input logic [19:0] a);
        return (a[19:12] == BASE_ADDR[19:12]);
    endfunction

    // Returns old_v with each byte whose strobe bit is set replaced from new_v
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;

    logic [19:0] addr_q, addr_d;         // AW latched while waiting for W
    logic [63:0] data_q, data_d;         // W latched while waiting for AW
    logic [7:0]  strb_q, strb_d;

    logic [63:0] scratch_q, scratch_d;
    logic [63:0] testpad_q, testpad_d;

    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // Commit path: the write that lands this cycle
    logic        commit_s;
    logic [19:0] cm_addr_s;
    logic [63:0] cm_data_s;
    logic [7:0]  cm_strb_s;

    logic        aw_hs_s, w_hs_s, ar_hs_s;
    logic [63:0] rd_val_s;

    // The low three address bits only pick a byte inside the 64-bit word.
    // They have no effect on the register decode.
    logic        unused_addr_bits_s;
    assign unused_addr_bits_s = ^{awaddr[2:0], araddr[2:0]};

    // A handshake needs the registered ready, not just the state.
    // The ready flops are held low while reset is asserted.
    assign aw_hs_s = awvalid & awready_q;
    assign w_hs_s  = wvalid  & wready_q;
    assign ar_hs_s = arvalid & arready_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // Write FSM: pairs the AW and W beats, whichever order they arrive in, and decides when to commit
    always_comb begin
        w_state_d = w_state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        commit_s  = 1'b0;
        cm_addr_s = awaddr;
        cm_data_s = wdata;
        cm_strb_s = wstrb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs_s) begin
                    addr_d    = awaddr;
                    w_state_d = W_HAVE_A;
                end else if (w_hs_s) begin
                    data_d    = wdata;
                    strb_d    = wstrb;
                    w_state_d = W_HAVE_D;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_A: begin
                cm_addr_s = addr_q;
                if (w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_A;
                end
            end
            W_HAVE_D: begin
                cm_data_s = data_q;
                cm_strb_s = strb_q;
                if (aw_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_D;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Register update and write response code for the committed write
    always_comb begin
        scratch_d = scratch_q;
        testpad_d = testpad_q;
        bresp_d   = bresp_q;
        if (commit_s) begin
            if (addr_hit(cm_addr_s)) begin
                bresp_d = RESP_OKAY;
                case (cm_addr_s[11:3])
                    OFS_SCRATCH: scratch_d = byte_merge(scratch_q, cm_data_s, cm_strb_s);
                    OFS_TESTPAD: testpad_d = byte_merge(testpad_q, cm_data_s, cm_strb_s);
                    default: begin
                        // DFH and unmapped offsets: the write is dropped
                        scratch_d = scratch_q;
                        testpad_d = testpad_q;
                    end
                endcase
            end else begin
                bresp_d = RESP_DECERR;
            end
        end else begin
            bresp_d = bresp_q;
        end
    end

    // Write-side handshake outputs, computed from the next state so that the flops reflect the current state
    always_comb begin
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // Read mux. It reads the current register flops, so a read in the same cycle as a write sees the old value.
    always_comb begin
        rd_val_s = 64'h0;
        if (addr_hit(araddr)) begin
            case (araddr[11:3])
                OFS_DFH:     rd_val_s = DFH_VALUE;
                OFS_SCRATCH: rd_val_s = scratch_q;
                OFS_TESTPAD: rd_val_s = testpad_q;
                default:     rd_val_s = 64'h0;
            endcase
        end else begin
            rd_val_s = 64'h0;
        end
    end

    // Read FSM: captures the data and response on accept, then holds them until rready
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rdata_d   = rd_val_s;
                    rresp_d   = addr_hit(araddr) ? RESP_OKAY : RESP_DECERR;
                    r_state_d = R_RESP;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------

    // State, storage and registered outputs. Reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            addr_q    <= 20'h0;
            data_q    <= 64'h0;
            strb_q    <= 8'h0;
            scratch_q <= 64'h0;
            testpad_q <= 64'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 64'h0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            scratch_q <= scratch_d;
            testpad_q <= testpad_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule
